// File: rtl/sprite_dma_pkg.sv
// Shared definitions for the sprite DMA engine: state encoding, default register
// addresses, bus direction values and the trigger decode helper.
package sprite_dma_pkg;

   localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_e;

   function automatic logic is_trigger(input logic [15:0] addr,
                                       input logic        rw,
                                       input logic [15:0] reg_addr);
      return (rw == RW_WRITE) && (addr == reg_addr);
   endfunction

endpackage

// File: rtl/sprite_dma_bus_mux.sv
// Combinational bus ownership mux: the CPU drives the system bus unless the
// DMA engine is active.
module sprite_dma_bus_mux (
   input  logic        i_dma_sel,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_data,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_eng_addr,
   input  logic [7:0]  i_eng_data,
   input  logic        i_eng_rw,
   output logic [15:0] o_bus_addr,
   output logic [7:0]  o_bus_data,
   output logic        o_bus_rw
);

   // Select the bus master.
   always_comb begin
      o_bus_addr = i_cpu_addr;
      o_bus_data = i_cpu_data;
      o_bus_rw   = i_cpu_rw;
      if (i_dma_sel) begin
         o_bus_addr = i_eng_addr;
         o_bus_data = i_eng_data;
         o_bus_rw   = i_eng_rw;
      end else begin
         o_bus_addr = i_cpu_addr;
         o_bus_data = i_cpu_data;
         o_bus_rw   = i_cpu_rw;
      end
   end

endmodule

// File: rtl/sprite_dma.sv
// OAM sprite DMA engine: a CPU write to the trigger register stalls the CPU and copies
// one page into the OAM data port. Define SPRITE_DMA_ALIGN_EN to add the get/put ALIGN cycle.
module sprite_dma
   import sprite_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
   parameter int          XFER_COUNT    = 256
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_data_out,
   input  logic        i_cpu_rw,
   input  logic [7:0]  i_bus_data_in,
   output logic        o_cpu_ce,
   output logic [15:0] o_bus_addr,
   output logic [7:0]  o_bus_data_out,
   output logic        o_bus_rw,
   output logic        o_dma_active
);

   localparam int CW = $clog2(XFER_COUNT) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(XFER_COUNT - 1);

   dma_state_e      r_state;
   dma_state_e      w_state_nxt;
   logic            r_parity;
   logic [CW-1:0]   r_counter;
   logic [7:0]      r_page;
   logic [7:0]      r_latch;
   logic            w_trigger;
   logic            w_cpu_ce;
   logic            w_dma_active;
   logic [15:0]     w_eng_addr;
   logic            w_eng_rw;

   assign w_trigger = is_trigger(i_cpu_addr, i_cpu_rw, DMA_REG_ADDR);

   // State register.
   always_ff @(posedge clock) begin
      if (nreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Get/put parity: even cycles are GET (read), odd cycles are PUT (write).
   always_ff @(posedge clock) begin
      if (nreset) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= ~r_parity;
      end
   end

   // Page, byte counter and read-data latch.
   always_ff @(posedge clock) begin
      if (nreset) begin
         r_page    <= 8'h00;
         r_counter <= '0;
         r_latch   <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_trigger) begin
                  r_page    <= i_cpu_data_out;
                  r_counter <= '0;
               end
            end
            ST_READ:  r_latch   <= i_bus_data_in;
            ST_WRITE: r_counter <= r_counter + CW'(1);
            default: ;
         endcase
      end
   end

   // Next-state and engine bus drive decoded from the registered state.
   always_comb begin
      w_state_nxt  = r_state;
      w_cpu_ce     = 1'b1;
      w_dma_active = 1'b0;
      w_eng_addr   = i_cpu_addr;
      w_eng_rw     = RW_READ;
      case (r_state)
         ST_IDLE: begin
            if (w_trigger) begin
               w_state_nxt = ST_HALT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HALT: begin
            w_cpu_ce     = 1'b0;
            w_dma_active = 1'b1;
`ifdef SPRITE_DMA_ALIGN_EN
            // Parity now odd means the next cycle is a GET slot.
            if (r_parity) begin
               w_state_nxt = ST_READ;
            end else begin
               w_state_nxt = ST_ALIGN;
            end
`else
            w_state_nxt  = ST_READ;
`endif
         end
`ifdef SPRITE_DMA_ALIGN_EN
         ST_ALIGN: begin
            w_cpu_ce     = 1'b0;
            w_dma_active = 1'b1;
            w_state_nxt  = ST_READ;
         end
`endif
         ST_READ: begin
            w_cpu_ce     = 1'b0;
            w_dma_active = 1'b1;
            w_eng_addr   = {r_page, r_counter[7:0]};
            w_eng_rw     = RW_READ;
            w_state_nxt  = ST_WRITE;
         end
         ST_WRITE: begin
            w_cpu_ce     = 1'b0;
            w_dma_active = 1'b1;
            w_eng_addr   = OAM_DATA_ADDR;
            w_eng_rw     = RW_WRITE;
            if (r_counter == LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   sprite_dma_bus_mux u_bus_mux (
      .i_dma_sel  (w_dma_active),
      .i_cpu_addr (i_cpu_addr),
      .i_cpu_data (i_cpu_data_out),
      .i_cpu_rw   (i_cpu_rw),
      .i_eng_addr (w_eng_addr),
      .i_eng_data (r_latch),
      .i_eng_rw   (w_eng_rw),
      .o_bus_addr (o_bus_addr),
      .o_bus_data (o_bus_data_out),
      .o_bus_rw   (o_bus_rw)
   );

   assign o_cpu_ce     = w_cpu_ce;
   assign o_dma_active = w_dma_active;

endmodule

// File: doc/sprite_dma.md
Name: sprite_dma

Overview:
- OAM DMA engine sitting between cpu_2a03 and the system bus.
- Snoops CPU writes to $4014. On a trigger it stalls the CPU through a clock-enable and copies 256 bytes from page $PP00-$PPFF to the PPU OAM data port $2004.
- While idle, CPU address, data and rw pass straight through to the bus.

Parameters:
- DMA_REG_ADDR, 16'h4014: trigger register address.
- OAM_DATA_ADDR, 16'h2004: destination address for every write.
- XFER_COUNT, 256: bytes per transfer; the counter width is clog2(XFER_COUNT)+1.

Ports:
- clock  in  1  system CPU clock (about 1.79 MHz).
- nreset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  address from the CPU.
- cpu_data_out  in  8  write data from the CPU.
- cpu_rw  in  1  CPU direction (0 = write, 1 = read).
- bus_data_in  in  8  read data returned from memory.
- cpu_ce  out  1  CPU clock enable; 0 stalls the CPU.
- bus_addr  out  16  system address bus.
- bus_data_out  out  8  system write data.
- bus_rw  out  1  system direction (0 = write, 1 = read).
- dma_active  out  1  high while the engine owns the bus.

Behaviour:
- Reset (nreset high):
  - State IDLE; parity=0; counter=0; page=0; latch=0.
  - cpu_ce=1 and dma_active=0; bus outputs follow the CPU combinationally.
- Parity:
  - 1-bit get/put toggle, flips every clock whenever not in reset.
  - Even = GET, odd = PUT.
- IDLE:
  - Trigger condition: cpu_rw=0 and cpu_addr==DMA_REG_ADDR in cycle t.
  - On trigger, latch page=cpu_data_out and go to HALT at t+1.
  - The CPU write itself completes on the bus normally.
- HALT (1 cycle):
  - cpu_ce=0, dma_active=1; bus_addr=cpu_addr, bus_rw=1 (dummy read).
  - Next state is READ if next-cycle parity is even; otherwise ALIGN.
- ALIGN (1 cycle):
  - Same bus drive as HALT; next state READ.
- READ:
  - bus_addr={page, counter[7:0]}, bus_rw=1.
  - Latch bus_data_in at the clock edge; next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_rw=0, bus_data_out=latch.
  - Increment counter.
  - If the counter was XFER_COUNT-1, go to IDLE; otherwise go to READ.
- Stall window:
  - cpu_ce=0 in HALT, ALIGN, READ and WRITE; cpu_ce=1 in IDLE.
  - Total stall is 1+2*256 = 513 cycles, or 514 with ALIGN.
  - cpu_ce returns to 1 in the cycle after the final WRITE.
- Address arithmetic: the source low byte wraps only within the page; page never increments.
- Boundary conditions:
  - $4014 writes seen on cpu_* while not IDLE are ignored. The CPU is stalled, so none are expected.
  - Reset mid-transfer: return to IDLE the next edge, cpu_ce=1; OAM is left partially written.
  - CPU reads of $4014 do not trigger.
  - page=$FF is legal.
  - Back-to-back trigger: the first CPU write after DMA completes may retrigger immediately.
- All control outputs are registered-state decodes. The bus mux is combinational from state and cpu_*.

Optional Feature:
- Macro: SPRITE_DMA_ALIGN_EN.
- Defined: the parity/ALIGN logic above applies, giving a 513- or 514-cycle stall.
- Undefined: the ALIGN state is removed and HALT always goes to READ, giving a fixed 513-cycle stall; the parity flop is still present.

Decomposition:
- Shared include sprite_dma_defs.v:
  - state encodings (IDLE, HALT, ALIGN, READ, WRITE);
  - default DMA_REG_ADDR and OAM_DATA_ADDR;
  - the `RW_READ/`RW_WRITE values reused from control_values.v.
- Natural sub-module: dma_bus_mux, the combinational selection of bus_addr, bus_data_out and bus_rw between the CPU and the engine. The FSM, counters and latch stay in sprite_dma.

Test Plan:
- Idle passthrough: CPU reads $8000 with rw=1 -> bus_addr=$8000, bus_rw=1, cpu_ce=1, dma_active=0.
- Even-aligned trigger: write $02 to $4014 at cycle t, with parity at t+2 even -> 513 cycles of cpu_ce=0.
  - First READ drives $0200, then WRITE drives $2004 with the data read.
  - Memory pattern mem[$02nn]=nn^$A5 yields 256 OAM writes of nn^$A5, in order.
- Odd-aligned trigger, SPRITE_DMA_ALIGN_EN defined: write $07 to $4014 one cycle later than the previous case -> 514 stall cycles.
  - ALIGN occurs once; the first READ address is $0700.
- Same stimulus with SPRITE_DMA_ALIGN_EN undefined -> exactly 513 stall cycles.
- Reset mid-transfer: assert nreset after 100 WRITEs -> next cycle state IDLE, cpu_ce=1, bus follows the CPU.
  - A subsequent $4014 write of $03 runs a full transfer from $0300.
- Page wrap: page $FF, final READ at $FFFF -> the next state is IDLE, with no access to $0000 or $10000.
